factorial_sched: RTL

//  Sequencer/arbiter for the shared iterative factorial datapath (inicio/whilen/whilej/fine strobes).

---
 rtl/factorial_sched.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/factorial_sched.sv
// Round-robin sequencer in front of the shared iterative factorial datapath:
// grants one requester, steps the datapath through its strobes, and returns n! (or an error).
module factorial_sched #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned W       = 32,
    parameter int unsigned MAX_N   = 12,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*W-1:0]         req_n,
    output logic [NREQ-1:0]           req_ready,
    output logic [W-1:0]              dp_n,
    output logic                      dp_inicio,
    output logic                      dp_whilen,
    output logic                      dp_whilej,
    output logic                      dp_fine,
    input  logic                      dp_ngt0,
    input  logic                      dp_jgt1,
    input  logic [W-1:0]              dp_rslt,
    output logic                      resp_valid,
    output logic [$clog2(NREQ)-1:0]   resp_id,
    output logic [W-1:0]              resp_rslt,
    output logic                      resp_err,
    input  logic                      resp_ready,
    output logic                      busy
);

    localparam int unsigned IDW = $clog2(NREQ);
    localparam int unsigned WDW = $clog2(TIMEOUT + 1);

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_INIT = 4'd1;
    localparam logic [3:0] S_CHKN = 4'd2;
    localparam logic [3:0] S_DECN = 4'd3;
    localparam logic [3:0] S_CHKJ = 4'd4;
    localparam logic [3:0] S_ACCJ = 4'd5;
    localparam logic [3:0] S_FINE = 4'd6;
    localparam logic [3:0] S_REJ  = 4'd7;
    localparam logic [3:0] S_RESP = 4'd8;

    logic [3:0]     r_state;
    logic [IDW-1:0] r_rr;
    logic [WDW-1:0] r_wd;
    logic [W-1:0]   r_dp_n;
    logic [IDW-1:0] r_resp_id;
    logic [W-1:0]   r_resp_rslt;
    logic           r_resp_err;

    logic           w_gnt_hit;
    logic [IDW-1:0] w_gnt_idx;
    logic [IDW-1:0] w_scan;
    logic [NREQ-1:0] w_gnt_oh;
    logic [W-1:0]   w_gnt_n;
    logic [IDW-1:0] w_rr_nxt;
    logic           w_in_loop;
    logic           w_wd_exp;

    // Scan starts at the rr pointer and wraps; first pending requester wins.
    always_comb begin
        w_gnt_hit = 1'b0;
        w_gnt_idx = '0;
        w_scan    = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            w_scan = IDW'((32'(r_rr) + k) % NREQ);
            if (!w_gnt_hit && req_valid[w_scan]) begin
                w_gnt_hit = 1'b1;
                w_gnt_idx = w_scan;
            end
        end
    end

    always_comb begin
        w_gnt_n = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (w_gnt_idx == IDW'(k)) begin
                w_gnt_n = req_n[k*W +: W];
            end
        end
    end

    assign w_gnt_oh  = w_gnt_hit ? (NREQ'(1) << w_gnt_idx) : '0;
    assign w_rr_nxt  = IDW'((32'(w_gnt_idx) + 32'd1) % NREQ);
    assign w_in_loop = (r_state == S_CHKN) || (r_state == S_DECN) ||
                       (r_state == S_CHKJ) || (r_state == S_ACCJ);
    assign w_wd_exp  = w_in_loop && (r_wd == WDW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_rr        <= '0;
            r_wd        <= '0;
            r_dp_n      <= '0;
            r_resp_id   <= '0;
            r_resp_rslt <= '0;
            r_resp_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_hit) begin
                        r_dp_n    <= w_gnt_n;
                        r_resp_id <= w_gnt_idx;
                        r_rr      <= w_rr_nxt;
                        r_state   <= (w_gnt_n > W'(MAX_N)) ? S_REJ : S_INIT;
                    end
                end
                S_INIT: begin
                    r_wd <= '0;
                    if (r_dp_n == '0) begin
                        r_resp_rslt <= W'(1);
                        r_resp_err  <= 1'b0;
                        r_state     <= S_RESP;
                    end else begin
                        r_state <= S_CHKN;
                    end
                end
                S_CHKN: r_state <= dp_ngt0 ? S_DECN : S_FINE;
                S_DECN: r_state <= S_CHKJ;
                S_CHKJ: r_state <= dp_jgt1 ? S_ACCJ : S_CHKN;
                S_ACCJ: r_state <= S_CHKJ;
                S_FINE: begin
                    r_resp_rslt <= dp_rslt;
                    r_resp_err  <= 1'b0;
                    r_state     <= S_RESP;
                end
                S_REJ: begin
                    r_resp_rslt <= '0;
                    r_resp_err  <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // Watchdog placed after the case so an expiry overrides the loop transition.
            if (w_in_loop) begin
                if (w_wd_exp) begin
                    r_resp_rslt <= '0;
                    r_resp_err  <= 1'b1;
                    r_state     <= S_RESP;
                end else begin
                    r_wd <= r_wd + 1'b1;
                end
            end
        end
    end

    assign req_ready  = ((r_state == S_IDLE) && !rst) ? w_gnt_oh : '0;
    assign dp_n       = r_dp_n;
    assign dp_inicio  = (r_state == S_INIT);
    assign dp_whilen  = (r_state == S_DECN);
    assign dp_whilej  = (r_state == S_ACCJ);
    assign dp_fine    = (r_state == S_FINE);
    assign resp_valid = (r_state == S_RESP);
    assign resp_id    = r_resp_id;
    assign resp_rslt  = r_resp_rslt;
    assign resp_err   = r_resp_err;
    assign busy       = (r_state != S_IDLE);

    a_strobe_onehot: assert property (@(posedge clk)
        $onehot0({dp_inicio, dp_whilen, dp_whilej, dp_fine}));
    a_grant_onehot: assert property (@(posedge clk) $onehot0(req_ready));
    a_resp_hold: assert property (@(posedge clk) disable iff (rst)
        (resp_valid && !resp_ready) |=> (resp_valid && $stable(resp_rslt) &&
                                        $stable(resp_err) && $stable(resp_id)));

endmodule
